l1_l2_sched: RTL and testbench
==============================

# l1_l2_sched

Two-requester scheduler that shares the single L2 cache port between the L1 I-cache and L1 D-cache miss/writeback paths. It sits between the two L1 caches' `pmem_*` ports and the L2 `l2_mem_*` port. It latches one winner per transaction and holds the downstream request stable until the L2 responds. It routes response and read data back only to the winner. Default policy is D-priority with an I-starvation bound; round-robin is selectable at compile time.

## Interface
Parameters:
- MAX_D_STREAK, 4: consecutive contended D grants allowed before I is forced; legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- i_read, i_write  in  1 each  I-side line read / line write request.
- i_address  in  lc3b_word  I-side line address.
- i_wdata  in  cache_line  I-side write line.
- i_rdata  out  cache_line  read line returned to I-side.
- i_resp  out  1  I-side transaction complete.
- d_read, d_write, d_address, d_wdata, d_rdata, d_resp: D-side equivalents, same widths and directions.
- l2_read, l2_write  out  1 each  downstream request.
- l2_address  out  lc3b_word  downstream address.
- l2_wdata  out  cache_line  downstream write line.
- l2_byte_enable  out  2  always 2'b11 while l2_read or l2_write is high, else 2'b00.
- l2_rdata  in  cache_line  L2 read line.
- l2_resp  in  1  L2 transaction complete.

## Operation
- FSM states are IDLE, SERVE_I and SERVE_D.
- IDLE:
  - No pending request: stay in IDLE.
  - Only one side pending (read|write): go to that side's SERVE state.
  - Both sides pending: apply the policy below.
- SERVE_x:
  - Drive l2_read, l2_write, l2_address and l2_wdata from requester x's live inputs.
  - On l2_resp: pulse x_resp and pass l2_rdata to x_rdata in the same cycle, then return to IDLE.
- Requester x must hold its request and operands stable until x_resp.
- If x asserts read and write together, l2_write=1 and l2_read=0 (write wins).
- The non-granted side's resp is 0. Its rdata is don't-care; it is driven with l2_rdata and must not be relied on.
- Default policy:
  - D wins contention.
  - 3-bit `streak` counter increments on each D grant made while I was pending.
  - When streak == MAX_D_STREAK, the next contention is granted to I.
  - streak clears on any I grant, and on any D grant made while I was not pending.
- l2_resp arriving in IDLE is ignored: no resp is forwarded and the state is unchanged.

## Timing
- Reset values:
  - State = IDLE, streak = 0.
  - Round-robin pointer (if compiled in) = D.
  - All outputs 0: l2_read, l2_write, l2_byte_enable = 0, i_resp = d_resp = 0, l2_address = 0, l2_wdata = 0.
- Grant latency: a request first seen in IDLE at cycle N produces l2_read or l2_write high from cycle N+1.
- The response path is combinational: x_resp = l2_resp & (state == SERVE_x).
- Turnaround is one mandatory IDLE cycle between transactions. The L1 deasserts its request on its resp cycle, so the IDLE cycle samples fresh requests.
- Best-case occupancy per transaction is L2 latency + 1 cycle.
- Reset mid-transaction: the state returns to IDLE and downstream requests drop on the next edge. An l2_resp in the reset cycle is not forwarded.
- Downstream outputs are 0 whenever the state is IDLE.

## Configuration
- `SCHED_RR_EN` defined:
  - streak and MAX_D_STREAK are unused.
  - A 1-bit pointer names the last granted side.
  - Contention is granted to the side that was not last granted.
  - The pointer updates on every grant, contended or not.
- `SCHED_RR_EN` undefined: D-priority with the starvation bound, as in Operation.
- Uncontended behaviour is identical in both builds.

## Test plan
- Single I read (i_address=16'h1000) with L2 responding 3 cycles after l2_read -> l2_read asserted the cycle after i_read; i_resp pulses 1 cycle with i_rdata = l2_rdata; d_resp stays 0.
- I read and D write asserted on the same cycle, default build -> l2_write first with l2_address = d_address; I is granted after the IDLE bubble.
- I held pending while D requests back-to-back, MAX_D_STREAK=4, default build -> exactly 4 D grants, then an I grant, then streak = 0.
- Same contention, `SCHED_RR_EN` build, starting from reset -> grant order I, D, I, D.
- rst asserted in the middle of SERVE_D with l2_resp arriving in the same cycle -> d_resp = 0; the next cycle shows state IDLE and all outputs 0.
- d_read and d_write asserted together -> l2_write = 1, l2_read = 0, l2_byte_enable = 2'b11.

Source files
------------

// File: rtl/l1_l2_sched.sv
// l1_l2_sched: shares the single L2 port between the L1 I-cache and D-cache.
// Default policy is D-priority with an I-starvation bound; define SCHED_RR_EN for round-robin.
module l1_l2_sched #(
   parameter  int unsigned MAX_D_STREAK = 4,
   localparam int unsigned ADDR_W       = 16,
   localparam int unsigned LINE_W       = 128
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_address,
   input  logic [LINE_W-1:0] i_wdata,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   output logic [1:0]        l2_byte_enable,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   localparam int unsigned STREAK_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t state;
   state_t state_next;
   logic   i_req;
   logic   d_req;
   logic   grant_i;
   logic   grant_d;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

`ifdef SCHED_RR_EN
   // Names the side granted most recently; contention goes to the other one.
   logic last_d;

   always_ff @(posedge clk) begin
      if (rst)          last_d <= 1'b1;
      else if (grant_i) last_d <= 1'b0;
      else if (grant_d) last_d <= 1'b1;
   end
`else
   // Counts D grants made while I was waiting; reaching the bound hands the next contention to I.
   logic [STREAK_W-1:0] streak;

   always_ff @(posedge clk) begin
      if (rst)          streak <= '0;
      else if (grant_i) streak <= '0;
      else if (grant_d) streak <= i_req ? streak + STREAK_W'(1) : '0;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and grant decision
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      unique case (state)
         IDLE: begin
            if (i_req && d_req) begin
`ifdef SCHED_RR_EN
               if (last_d) grant_i = 1'b1;
               else        grant_d = 1'b1;
`else
               if (streak == STREAK_W'(MAX_D_STREAK)) grant_i = 1'b1;
               else                                    grant_d = 1'b1;
`endif
            end else if (i_req) begin
               grant_i = 1'b1;
            end else if (d_req) begin
               grant_d = 1'b1;
            end
            if (grant_i)      state_next = SERVE_I;
            else if (grant_d) state_next = SERVE_D;
         end
         SERVE_I, SERVE_D: begin
            if (l2_resp) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Downstream request mirrors the winner's live inputs; write wins over read
   always_comb begin
      l2_read        = 1'b0;
      l2_write       = 1'b0;
      l2_address     = '0;
      l2_wdata       = '0;
      l2_byte_enable = 2'b00;
      i_resp         = 1'b0;
      d_resp         = 1'b0;
      unique case (state)
         SERVE_I: begin
            l2_write   = i_write;
            l2_read    = i_read & ~i_write;
            l2_address = i_address;
            l2_wdata   = i_wdata;
            i_resp     = l2_resp & ~rst;
         end
         SERVE_D: begin
            l2_write   = d_write;
            l2_read    = d_read & ~d_write;
            l2_address = d_address;
            l2_wdata   = d_wdata;
            d_resp     = l2_resp & ~rst;
         end
         default: ;
      endcase
      if (l2_read || l2_write) l2_byte_enable = 2'b11;
   end

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_sched.sv
// tb_l1_l2_sched: directed and randomized checks of l1_l2_sched against a transaction-level
// reference model (D-priority with starvation bound, or round-robin when SCHED_RR_EN is defined).
module tb_l1_l2_sched;

   localparam int unsigned MAX_D = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [15:0]   i_address = '0;
   logic [127:0]  i_wdata = '0;
   logic [127:0]  i_rdata;
   logic          i_resp;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [15:0]   d_address = '0;
   logic [127:0]  d_wdata = '0;
   logic [127:0]  d_rdata;
   logic          d_resp;
   logic          l2_read, l2_write;
   logic [15:0]   l2_address;
   logic [127:0]  l2_wdata;
   logic [1:0]    l2_byte_enable;
   logic [127:0]  l2_rdata = '0;
   logic          l2_resp = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   l1_l2_sched #(.MAX_D_STREAK(MAX_D)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_byte_enable(l2_byte_enable), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      step();
      rst = 1'b1;
      i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [149:0] act;
      step();
      rst = 1'b1; i_read = 1'b1; d_write = 1'b1; l2_resp = 1'b1;
      step();
      step();
      @(negedge clk);
      act = {l2_read, l2_write, l2_byte_enable, l2_address, l2_wdata, i_resp, d_resp};
      n_tests++;
      if (act !== 150'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", act);
      end
      do_reset();
   endtask

   task automatic test_single_i_read();
      logic [127:0] rd;
      do_reset();
      rd = {$urandom, $urandom, $urandom, $urandom};
      i_read = 1'b1; i_address = 16'h1000; i_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_idle_cycle: got %b expected 00", {l2_read, l2_write});
      end
      step();
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_write, l2_byte_enable, l2_address, i_resp, d_resp} !== {1'b1, 1'b0, 2'b11, 16'h1000, 2'b00}) begin
         n_fail++;
         $display("FAIL single_grant: got %h expected %h",
                  {l2_read, l2_write, l2_byte_enable, l2_address, i_resp, d_resp},
                  {1'b1, 1'b0, 2'b11, 16'h1000, 2'b00});
      end
      for (int k = 0; k < 2; k++) begin
         step();
         @(negedge clk);
         n_tests++;
         if ({l2_read, i_resp, d_resp} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_hold_%0d: got %b expected 100", k, {l2_read, i_resp, d_resp});
         end
      end
      step();
      l2_resp = 1'b1; l2_rdata = rd;
      @(negedge clk);
      n_tests++;
      if ({i_resp, d_resp, i_rdata} !== {2'b10, rd}) begin
         n_fail++;
         $display("FAIL single_resp: got %h expected %h", {i_resp, d_resp, i_rdata}, {2'b10, rd});
      end
      step();
      l2_resp = 1'b0; i_read = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_write, l2_byte_enable, i_resp, d_resp} !== 6'd0) begin
         n_fail++;
         $display("FAIL single_after: got %b expected 0", {l2_read, l2_write, l2_byte_enable, i_resp, d_resp});
      end
   endtask

   task automatic test_contention();
      logic [127:0] wd;
      logic [127:0] rd;
      logic         first_d;
      logic [15:0]  a1, a2;
`ifdef SCHED_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      do_reset();
      wd = {$urandom, $urandom, $urandom, $urandom};
      rd = {$urandom, $urandom, $urandom, $urandom};
      a1 = first_d ? 16'h8abc : 16'h1234;
      a2 = first_d ? 16'h1234 : 16'h8abc;
      i_read = 1'b1; i_address = 16'h1234;
      d_write = 1'b1; d_address = 16'h8abc; d_wdata = wd;
      step();
      @(negedge clk);
      n_tests++;
      if ({l2_write, l2_read, l2_address} !== {first_d, ~first_d, a1}) begin
         n_fail++;
         $display("FAIL contend_first: got %h expected %h", {l2_write, l2_read, l2_address}, {first_d, ~first_d, a1});
      end
      step();
      l2_resp = 1'b1; l2_rdata = rd;
      @(negedge clk);
      n_tests++;
      if ({d_resp, i_resp} !== {first_d, ~first_d}) begin
         n_fail++;
         $display("FAIL contend_first_resp: got %b expected %b", {d_resp, i_resp}, {first_d, ~first_d});
      end
      step();
      l2_resp = 1'b0;
      if (first_d) d_write = 1'b0; else i_read = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_write, l2_byte_enable} !== 4'd0) begin
         n_fail++;
         $display("FAIL contend_bubble: got %b expected 0000", {l2_read, l2_write, l2_byte_enable});
      end
      step();
      @(negedge clk);
      n_tests++;
      if ({l2_write, l2_read, l2_address} !== {~first_d, first_d, a2}) begin
         n_fail++;
         $display("FAIL contend_second: got %h expected %h", {l2_write, l2_read, l2_address}, {~first_d, first_d, a2});
      end
      step();
      l2_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({d_resp, i_resp} !== {~first_d, first_d}) begin
         n_fail++;
         $display("FAIL contend_second_resp: got %b expected %b", {d_resp, i_resp}, {~first_d, first_d});
      end
      step();
      l2_resp = 1'b0; i_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic test_rw_both();
      logic [127:0] wd;
      do_reset();
      wd = {$urandom, $urandom, $urandom, $urandom};
      d_read = 1'b1; d_write = 1'b1; d_address = 16'h8ace; d_wdata = wd;
      step();
      @(negedge clk);
      n_tests++;
      if ({l2_write, l2_read, l2_byte_enable, l2_address, l2_wdata} !== {1'b1, 1'b0, 2'b11, 16'h8ace, wd}) begin
         n_fail++;
         $display("FAIL rw_both: got %h expected %h", {l2_write, l2_read, l2_byte_enable, l2_address, l2_wdata},
                  {1'b1, 1'b0, 2'b11, 16'h8ace, wd});
      end
      step();
      l2_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({d_resp, i_resp} !== 2'b10) begin
         n_fail++;
         $display("FAIL rw_both_resp: got %b expected 10", {d_resp, i_resp});
      end
      step();
      l2_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
   endtask

   task automatic test_streak();
      int  grants[10];
      int  n_g;
      int  exp_side;
      bit  prev_req;
      bit  req;
      bit  resp_next;
      do_reset();
      n_g = 0; prev_req = 1'b0; resp_next = 1'b0;
      i_read = 1'b1; i_address = 16'h1000;
      d_write = 1'b1; d_address = 16'h8000; d_wdata = {$urandom, $urandom, $urandom, $urandom};
      for (int cyc = 0; cyc < 200 && n_g < 10; cyc++) begin
         @(negedge clk);
         req = l2_read | l2_write;
         if (req && !prev_req) begin
            grants[n_g] = l2_address[15] ? 2 : 1;
            n_g++;
         end
         resp_next = req && !l2_resp;
         prev_req  = req;
         step();
         l2_resp = resp_next;
      end
      n_tests++;
      if (n_g < 10) begin
         n_fail++;
         $display("FAIL streak_timeout: got %0d grants expected 10", n_g);
      end
      for (int k = 0; k < n_g; k++) begin
`ifdef SCHED_RR_EN
         exp_side = (k % 2 == 0) ? 1 : 2;
`else
         exp_side = (k % (MAX_D + 1) == MAX_D) ? 1 : 2;
`endif
         n_tests++;
         if (grants[k] !== exp_side) begin
            n_fail++;
            $display("FAIL streak_grant_%0d: got side %0d expected side %0d (1=I 2=D)", k, grants[k], exp_side);
         end
      end
      i_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_read = 1'b1; d_address = 16'h8444;
      step();
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_address} !== {1'b1, 16'h8444}) begin
         n_fail++;
         $display("FAIL rstmid_serving: got %h expected %h", {l2_read, l2_address}, {1'b1, 16'h8444});
      end
      step();
      rst = 1'b1; l2_resp = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({d_resp, i_resp} !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_resp: got %b expected 00", {d_resp, i_resp});
      end
      step();
      rst = 1'b0; l2_resp = 1'b0; d_read = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({l2_read, l2_write, l2_byte_enable, l2_address, l2_wdata, i_resp, d_resp} !== 150'd0) begin
         n_fail++;
         $display("FAIL rstmid_after: got %h expected 0",
                  {l2_read, l2_write, l2_byte_enable, l2_address, l2_wdata, i_resp, d_resp});
      end
   endtask

   task automatic test_random();
      int unsigned  m_srv, m_nxt, lat, win, kind;
      bit           i_drop, d_drop, ir, dr;
      logic         e_r, e_w, e_ir, e_dr;
      logic [15:0]  e_a;
      logic [127:0] e_d;
      logic [149:0] act, exp_v;
      int           n_rdata_bad;
`ifdef SCHED_RR_EN
      bit           last_d;
`else
      int unsigned  d_wins;
`endif
      do_reset();
      m_nxt = 0; lat = 0; i_drop = 1'b0; d_drop = 1'b0; n_rdata_bad = 0;
`ifdef SCHED_RR_EN
      last_d = 1'b1;
`else
      d_wins = 0;
`endif
      for (int cyc = 0; cyc < 1500; cyc++) begin
         m_srv = m_nxt;
         if (i_drop) begin i_read = 1'b0; i_write = 1'b0; i_drop = 1'b0; end
         if (d_drop) begin d_read = 1'b0; d_write = 1'b0; d_drop = 1'b0; end
         if (!i_read && !i_write && $urandom_range(0, 2) == 0) begin
            kind = $urandom_range(0, 3);
            i_read = (kind != 2); i_write = (kind >= 2);
            i_address = {1'b0, 15'($urandom)};
            i_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if (!d_read && !d_write && $urandom_range(0, 1) == 0) begin
            kind = $urandom_range(0, 3);
            d_read = (kind != 2); d_write = (kind >= 2);
            d_address = {1'b1, 15'($urandom)};
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
         end
         if (m_srv != 0) begin
            l2_resp = (lat == 0);
            if (lat != 0) lat--;
         end else begin
            l2_resp = ($urandom_range(0, 7) == 0);
         end
         l2_rdata = {$urandom, $urandom, $urandom, $urandom};

         @(negedge clk);
         e_r = 1'b0; e_w = 1'b0; e_a = '0; e_d = '0; e_ir = 1'b0; e_dr = 1'b0;
         m_nxt = m_srv;
         if (m_srv == 0) begin
            ir = i_read | i_write;
            dr = d_read | d_write;
            win = 0;
            if (ir && dr) begin
`ifdef SCHED_RR_EN
               win = last_d ? 1 : 2;
`else
               win = (d_wins == MAX_D) ? 1 : 2;
`endif
            end else if (ir) begin
               win = 1;
            end else if (dr) begin
               win = 2;
            end
`ifdef SCHED_RR_EN
            if (win != 0) last_d = (win == 2);
`else
            if (win == 2 && ir) d_wins++;
            else if (win != 0) d_wins = 0;
`endif
            m_nxt = win;
            lat = $urandom_range(0, 3);
         end else if (m_srv == 1) begin
            e_w = i_write; e_r = i_read & ~i_write; e_a = i_address; e_d = i_wdata; e_ir = l2_resp;
            if (l2_resp) begin m_nxt = 0; i_drop = 1'b1; end
         end else begin
            e_w = d_write; e_r = d_read & ~d_write; e_a = d_address; e_d = d_wdata; e_dr = l2_resp;
            if (l2_resp) begin m_nxt = 0; d_drop = 1'b1; end
         end
         exp_v = {e_r, e_w, (e_r | e_w) ? 2'b11 : 2'b00, e_a, e_d, e_ir, e_dr};
         act   = {l2_read, l2_write, l2_byte_enable, l2_address, l2_wdata, i_resp, d_resp};
         n_tests++;
         if (act !== exp_v) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got %h expected %h", cyc, act, exp_v);
         end
         if (e_ir || e_dr) begin
            n_tests++;
            if ((e_ir ? i_rdata : d_rdata) !== l2_rdata) begin
               n_fail++;
               n_rdata_bad++;
               if (n_rdata_bad < 5)
                  $display("FAIL random_rdata_cyc%0d: got %h expected %h", cyc, e_ir ? i_rdata : d_rdata, l2_rdata);
            end
         end
         step();
      end
      i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_i_read();
      test_contention();
      test_rw_both();
      test_streak();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
